mips_memory_arbiter: RTL

- Shares one single-ported data memory between two requesters: the pipeline MEM stage (pipe port) and an external loader/debug port (ext port).
- Sequences each access over a fixed number of memory cycles and returns the read data.
- Stalls the pipeline while a pipe access is pending or in flight.
- Sits between the MEM stage logic and the data-memory datapath.

---
 rtl/mips_memory_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mips_memory_arbiter.sv
// Arbiter sharing one single-ported data memory between the pipeline MEM stage and an external port.
// Define MIPS_MEMORY_ARBITER_STATS_EN to add saturating grant and stall counters.
module mips_memory_arbiter #(
    parameter int ADDR_L        = 64,
    parameter int ADDR_W        = $clog2(ADDR_L),
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_done,
    output logic              pipe_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_grant,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MIPS_MEMORY_ARBITER_STATS_EN
    ,
    output logic [15:0]       stat_pipe_grants,
    output logic [15:0]       stat_ext_grants,
    output logic [15:0]       stat_stall_cycles
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam logic       OWN_PIPE = 1'b0;
    localparam logic       OWN_EXT  = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg;
    logic                owner_reg;
    logic                last_grant_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   pipe_rdata_reg;
    logic [DATA_W-1:0]   ext_rdata_reg;
    logic                grant;
    logic                grant_owner;
    logic                capture;

    always_comb begin
        state_next  = state_reg;
        grant       = 1'b0;
        grant_owner = OWN_PIPE;
        case (state_reg)
            ST_IDLE: begin
                if (pipe_req && ext_req) begin
                    grant       = 1'b1;
                    grant_owner = ~last_grant_reg;
                end else if (pipe_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_PIPE;
                end else if (ext_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_EXT;
                end
                if (grant) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_reg == 4'd1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Read data is only valid in the final BUSY cycle of the access.
    assign capture = (state_reg == ST_BUSY) && (cnt_reg == 4'd1) && !we_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            owner_reg      <= OWN_PIPE;
            last_grant_reg <= OWN_EXT;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            pipe_rdata_reg <= '0;
            ext_rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_reg      <= grant_owner;
                last_grant_reg <= grant_owner;
                we_reg         <= (grant_owner == OWN_PIPE) ? pipe_we    : ext_we;
                addr_reg       <= (grant_owner == OWN_PIPE) ? pipe_addr  : ext_addr;
                wdata_reg      <= (grant_owner == OWN_PIPE) ? pipe_wdata : ext_wdata;
                cnt_reg        <= CNT_LOAD;
            end else if (state_reg == ST_BUSY) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (capture && (owner_reg == OWN_PIPE)) begin
                pipe_rdata_reg <= mem_rdata;
            end
            if (capture && (owner_reg == OWN_EXT)) begin
                ext_rdata_reg <= mem_rdata;
            end
        end
    end

    assign mem_en     = (state_reg == ST_BUSY);
    assign mem_we     = mem_en & we_reg;
    assign mem_addr   = mem_en ? addr_reg  : '0;
    assign mem_wdata  = mem_en ? wdata_reg : '0;
    assign pipe_done  = (state_reg == ST_DONE) && (owner_reg == OWN_PIPE);
    assign ext_done   = (state_reg == ST_DONE) && (owner_reg == OWN_EXT);
    assign ext_grant  = (state_reg != ST_IDLE) && (owner_reg == OWN_EXT);
    // Gated by reset so every output reads 0 while reset is held.
    assign pipe_stall = reset & pipe_req & ~pipe_done;
    assign pipe_rdata = pipe_rdata_reg;
    assign ext_rdata  = ext_rdata_reg;

`ifdef MIPS_MEMORY_ARBITER_STATS_EN
    logic [15:0] stat_pipe_reg, stat_ext_reg, stat_stall_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_pipe_reg  <= 16'd0;
            stat_ext_reg   <= 16'd0;
            stat_stall_reg <= 16'd0;
        end else begin
            if (grant && (grant_owner == OWN_PIPE) && (stat_pipe_reg != 16'hFFFF)) begin
                stat_pipe_reg <= stat_pipe_reg + 16'd1;
            end
            if (grant && (grant_owner == OWN_EXT) && (stat_ext_reg != 16'hFFFF)) begin
                stat_ext_reg <= stat_ext_reg + 16'd1;
            end
            if (pipe_stall && (stat_stall_reg != 16'hFFFF)) begin
                stat_stall_reg <= stat_stall_reg + 16'd1;
            end
        end
    end

    assign stat_pipe_grants  = stat_pipe_reg;
    assign stat_ext_grants   = stat_ext_reg;
    assign stat_stall_cycles = stat_stall_reg;
`endif

endmodule
